// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor controller: one result bit per clock, LSB first,
// through a single one-bit add/subtract cell and a carry/borrow register.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    // state | meaning
    // IDLE  | waiting for start; result/cout hold the last completed operation
    // RUN   | one operand bit pair consumed per clock, LSB first
    // DONE  | one-cycle completion pulse; result/cout final
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             op_q;
    logic             carry;
    logic [CW-1:0]    bit_cnt;
    logic             last_bit;
    logic             a_bit;
    logic             b_bit;
    logic             axb;
    logic             sum_bit;
    logic             carry_nxt;

    assign last_bit = (bit_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last_bit) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single one-bit cell; the same xor term serves both add and subtract.
    assign a_bit     = a_sh[0];
    assign b_bit     = b_sh[0];
    assign axb       = a_bit ^ b_bit;
    assign sum_bit   = axb ^ carry;
    assign carry_nxt = op_q ? ((~a_bit & b_bit) | (~axb & carry))
                            : ((a_bit & b_bit) | (axb & carry));

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            op_q    <= 1'b0;
            carry   <= 1'b0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        op_q    <= op;
                        carry   <= 1'b0;
                        bit_cnt <= CW'(WIDTH - 1);
                    end
                end
                RUN: begin
                    // New bit enters at the MSB so bit i lands at index i after WIDTH shifts.
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {sum_bit, res_sh[WIDTH-1:1]};
                    carry  <= carry_nxt;
                    if (!last_bit) begin
                        bit_cnt <= bit_cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign result = res_sh;
    assign cout   = carry;

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  1  operation select, sampled with start: 0 = add (a+b), 1 = subtract (a-b).
REQ-006 a  input  WIDTH  first operand, sampled with start.
REQ-007 b  input  WIDTH  second operand, sampled with start.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  single-cycle pulse; result and cout are valid while high.
REQ-010 result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-011 cout  output  1  carry-out for add; borrow-out for subtract.

Function
REQ-012 The block SHALL compute results bit-serially, LSB first, one bit per clock, using a single one-bit half-adder/half-subtractor pair plus a carry/borrow register.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1 at edge k SHALL latch a, b and op, clear the carry/borrow register and bit index, and enter RUN.
REQ-015 IDLE with start=0 SHALL remain in IDLE.
REQ-016 Each edge in RUN SHALL process bit i. Add: s=a[i]^b[i]^c, c'=(a[i]&b[i])|((a[i]^b[i])&c). Subtract: d=a[i]^b[i]^c, c'=(~a[i]&b[i])|(~(a[i]^b[i])&c).
REQ-017 Each RUN edge SHALL shift the new bit into the result shift register MSB-first-fill, so that after WIDTH bits, result[i] holds bit i.
REQ-018 After the RUN edge processing bit WIDTH-1 (edge k+WIDTH), the FSM SHALL enter DONE.
REQ-019 In DONE: done=1, result holds the final value, cout holds the final carry/borrow.
REQ-020 The next edge after DONE SHALL return the FSM to IDLE unconditionally.
REQ-021 Latency: start accepted at edge k gives done=1 in the cycle following edge k+WIDTH, for exactly one cycle.
REQ-022 Throughput: at most one operation per WIDTH+2 cycles.
REQ-023 start SHALL be ignored in RUN and DONE; there is no queuing, and the in-flight operands are unaffected.
REQ-024 Changes on a, b or op after the start edge SHALL NOT affect the in-flight result.
REQ-025 result and cout SHALL hold their last completed values in IDLE until the next start is accepted.
REQ-026 After a start is accepted, result and cout SHALL be undefined to the consumer until done.
REQ-027 Wrap-around: add overflow drops to modulo 2^WIDTH with cout=1; subtract with a<b gives the two's-complement difference with cout=1.
REQ-028 No combinational path SHALL exist from inputs to outputs.

Reset
REQ-029 rst=1 at any edge SHALL force IDLE and clear busy, done, result, cout, the carry/borrow register, the bit index and the operand registers to 0.
REQ-030 Reset SHALL override start on the same edge.
REQ-031 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-032 After reset, the first start SHALL be accepted on the first edge where rst=0 and start=1.

Verification (WIDTH=8)
REQ-033 op=0, a=0x5A, b=0x33: result=0x8D, cout=0; done exactly 9 cycles after the start edge.
REQ-034 op=0, a=0xFF, b=0x01: result=0x00, cout=1.
REQ-035 op=1, a=0x10, b=0x01: result=0x0F, cout=0. Then op=1, a=0x00, b=0x01: result=0xFF, cout=1.
REQ-036 Start pulsed again at edge k+3 with a=0xAA, b=0x55: ignored; the first operation completes unchanged; busy stays high through DONE.
REQ-037 rst pulsed at edge k+4 mid-RUN: the next cycle shows busy=0, done=0, result=0x00, cout=0; no done pulse follows; a new start then completes normally.
REQ-038 Back-to-back: start held high continuously gives operations accepted every 10 cycles, each done a single-cycle pulse.
